// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin ALU/LSU register-file write-back arbiter with registered write port.
// Optional feature macro RF_WB_SCOREBOARD_EN adds the pending-write vector and decode stall.
module rf_wb_arbiter (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        lsu_valid,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   output logic        lsu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_rd_addr,
   output logic [31:0] rf_rd_in,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  chk_rs1,
   input  logic [4:0]  chk_rs2,
   output logic        stall,
   input  logic        flush
);

   typedef enum logic {PRI_ALU = 1'b0, PRI_LSU = 1'b1} pri_e;

   pri_e        pri_q, pri_d;
   logic        gnt_alu, gnt_lsu;
   logic        we_q, we_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;

   // Grants are suppressed during reset and flush so neither side sees a handshake.
   always_comb begin
      gnt_alu = 1'b0;
      gnt_lsu = 1'b0;
      pri_d   = pri_q;
      if (rst_n && !flush) begin
         if (alu_valid && lsu_valid) begin
            if (pri_q == PRI_ALU) begin
               gnt_alu = 1'b1;
               pri_d   = PRI_LSU;
            end else begin
               gnt_lsu = 1'b1;
               pri_d   = PRI_ALU;
            end
         end else begin
            gnt_alu = alu_valid;
            gnt_lsu = lsu_valid;
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pri_q <= PRI_ALU;
      end else begin
         pri_q <= pri_d;
      end
   end

   // Writes to x0 are accepted but dropped; address/data hold while no write is issued.
   always_comb begin
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      if (gnt_alu && (alu_rd != 5'd0)) begin
         we_d   = 1'b1;
         addr_d = alu_rd;
         data_d = alu_data;
      end else if (gnt_lsu && (lsu_rd != 5'd0)) begin
         we_d   = 1'b1;
         addr_d = lsu_rd;
         data_d = lsu_data;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         addr_q <= 5'd0;
         data_q <= 32'd0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign alu_ready  = gnt_alu;
   assign lsu_ready  = gnt_lsu;
   assign rf_we      = we_q;
   assign rf_rd_addr = addr_q;
   assign rf_rd_in   = data_q;

`ifdef RF_WB_SCOREBOARD_EN
   logic [31:0] pend_q, pend_d;

   // Set is applied after clear so a same-cycle re-issue keeps the bit pending.
   always_comb begin
      pend_d = pend_q;
      if (flush) begin
         pend_d = 32'd0;
      end else begin
         if (we_q) begin
            pend_d[addr_q] = 1'b0;
         end
         if (iss_valid) begin
            pend_d[iss_rd] = 1'b1;
         end
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= 32'd0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign stall = rst_n && (((chk_rs1 != 5'd0) && pend_q[chk_rs1]) ||
                            ((chk_rs2 != 5'd0) && pend_q[chk_rs2]));
`else
   logic unused_sb;
   assign unused_sb = ^{iss_valid, iss_rd, chk_rs1, chk_rs2};
   assign stall     = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter with a queue-based reference model.
module tb_rf_wb_arbiter;
`ifdef RF_WB_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        rst_n;
   logic        alu_valid, lsu_valid, iss_valid, flush;
   logic [4:0]  alu_rd, lsu_rd, iss_rd, chk_rs1, chk_rs2;
   logic [31:0] alu_data, lsu_data;
   logic        alu_ready, lsu_ready, rf_we, stall;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_in;

   rf_wb_arbiter dut (
      .clock(clock), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_in(rf_rd_in),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
      .stall(stall), .flush(flush)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit        ardy;
      bit        lrdy;
      bit        stl;
      bit        we;
      bit [4:0]  addr;
      bit [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;

   bit        m_pri_alu;
   bit        m_we;
   bit [4:0]  m_addr;
   bit [31:0] m_data;
   int        m_pend[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_pend(input int r);
      foreach (m_pend[i]) if (m_pend[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void drop_pend(input int r);
      int keep[$];
      foreach (m_pend[i]) if (m_pend[i] != r) keep.push_back(m_pend[i]);
      m_pend = keep;
   endfunction

   function automatic void model_reset();
      m_pri_alu = 1'b1;
      m_we      = 1'b0;
      m_addr    = 5'd0;
      m_data    = 32'd0;
      m_pend.delete();
   endfunction

   // Expected view of the current cycle from the applied inputs, then advance the model one edge.
   task automatic commit();
      exp_t e;
      int   who;
      who = 0;
      if (!flush) begin
         if (alu_valid && lsu_valid) begin
            who       = m_pri_alu ? 1 : 2;
            m_pri_alu = !m_pri_alu;
         end else if (alu_valid) begin
            who = 1;
         end else if (lsu_valid) begin
            who = 2;
         end
      end
      e.ardy = (who == 1);
      e.lrdy = (who == 2);
      e.stl  = SB_EN && (((chk_rs1 != 0) && is_pend(int'(chk_rs1))) ||
                         ((chk_rs2 != 0) && is_pend(int'(chk_rs2))));
      e.we   = m_we;
      e.addr = m_addr;
      e.data = m_data;
      sb.push_back(e);
      if (flush) begin
         m_pend.delete();
      end else begin
         if (m_we) drop_pend(int'(m_addr));
         if (iss_valid && (iss_rd != 0) && !is_pend(int'(iss_rd))) m_pend.push_back(int'(iss_rd));
      end
      m_we = 1'b0;
      if (who == 1 && alu_rd != 0) begin
         m_we = 1'b1; m_addr = alu_rd; m_data = alu_data;
      end
      if (who == 2 && lsu_rd != 0) begin
         m_we = 1'b1; m_addr = lsu_rd; m_data = lsu_data;
      end
   endtask

   always @(negedge clock) begin
      if (mon_en && sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("alu_ready", alu_ready, e.ardy);
         chk("lsu_ready", lsu_ready, e.lrdy);
         chk("stall", stall, e.stl);
         chk("rf_we", rf_we, e.we);
         chk("rf_rd_addr", rf_rd_addr, e.addr);
         chk("rf_rd_in", rf_rd_in, e.data);
      end
   end

   task automatic idle();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0; flush = 0;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic alu(input logic [4:0] rd, input logic [31:0] d);
      alu_valid = 1; alu_rd = rd; alu_data = d;
   endtask

   task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
      lsu_valid = 1; lsu_rd = rd; lsu_data = d;
   endtask

   initial begin
      idle();
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      alu(5'd9, 32'hDEAD);
      #1;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_addr", rf_rd_addr, 0);
      chk("rst_data", rf_rd_in, 0);
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_stall", stall, 0);

      // Dual requests straight out of reset alternate starting with the ALU.
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) next_cycle();
         if (i < 4) begin
            alu(5'd1, 32'h100 + i);
            lsu(5'd2, 32'h200 + i);
         end
         commit();
         #3;
         if (i < 4) begin
            chk("rr_alu_ready", alu_ready, (i % 2 == 0));
            chk("rr_lsu_ready", lsu_ready, (i % 2 == 1));
         end
         if (i > 0) chk("rr_addr", rf_rd_addr, (i % 2 == 1) ? 1 : 2);
      end

      next_cycle(); alu(5'd5, 32'h12345678); commit(); #3;
      chk("alu_only_ready", alu_ready, 1);
      next_cycle(); commit(); #3;
      chk("alu_only_we", rf_we, 1);
      chk("alu_only_addr", rf_rd_addr, 5);
      chk("alu_only_data", rf_rd_in, 32'h12345678);

      next_cycle(); lsu(5'd0, 32'hFFFFFFFF); commit(); #3;
      chk("x0_lsu_ready", lsu_ready, 1);
      next_cycle(); commit(); #3;
      chk("x0_we", rf_we, 0);
      chk("x0_hold_addr", rf_rd_addr, 5);

      next_cycle(); iss_valid = 1; iss_rd = 7; commit();
      next_cycle(); chk_rs1 = 7; alu(5'd7, 32'hAA); commit(); #3;
      chk("pend_stall", stall, SB_EN);
      next_cycle(); chk_rs1 = 7; iss_valid = 1; iss_rd = 7; commit(); #3;
      chk("pend_we7", rf_we, 1);
      chk("pend_stall_wr", stall, SB_EN);
      next_cycle(); chk_rs1 = 7; alu(5'd7, 32'hBB); commit(); #3;
      chk("reissue_stall", stall, SB_EN);
      next_cycle(); chk_rs1 = 7; commit(); #3;
      chk("reissue_we7", rf_we, 1);
      next_cycle(); chk_rs1 = 7; commit(); #3;
      chk("cleared_stall", stall, 0);

      next_cycle(); iss_valid = 1; iss_rd = 4; commit();
      next_cycle(); iss_valid = 1; iss_rd = 9; lsu(5'd11, 32'h11); commit();
      next_cycle(); flush = 1; alu(5'd6, 32'h66); iss_valid = 1; iss_rd = 12;
      chk_rs1 = 4; chk_rs2 = 9; commit(); #3;
      chk("flush_alu_ready", alu_ready, 0);
      chk("flush_stall_before", stall, SB_EN);
      next_cycle(); chk_rs1 = 4; chk_rs2 = 9; commit(); #3;
      chk("flush_we", rf_we, 0);
      chk("flush_stall", stall, 0);
      next_cycle(); chk_rs1 = 12; commit(); #3;
      chk("flush_iss_ignored", stall, 0);

      next_cycle(); iss_valid = 1; iss_rd = 3; alu(5'd3, 32'h33); commit();
      next_cycle(); chk_rs1 = 3; alu(5'd10, 32'hA0); lsu(5'd11, 32'hB0); commit();
      #2;
      mon_en = 1'b0;
      sb.delete();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", rf_we, 0);
      chk("mid_rst_addr", rf_rd_addr, 0);
      chk("mid_rst_data", rf_rd_in, 0);
      chk("mid_rst_alu_ready", alu_ready, 0);
      chk("mid_rst_lsu_ready", lsu_ready, 0);
      chk("mid_rst_stall", stall, 0);
      model_reset();
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      commit();
      mon_en = 1'b1;
      #3;
      chk("post_rst_alu_ready", alu_ready, 1);
      chk("post_rst_lsu_ready", lsu_ready, 0);
      chk("post_rst_stall", stall, 0);

      for (int n = 0; n < 400; n++) begin
         next_cycle();
         if ($urandom_range(3) != 0) alu(5'($urandom_range(7)), $urandom);
         if ($urandom_range(3) != 0) lsu(5'($urandom_range(7)), $urandom);
         iss_valid = ($urandom_range(2) == 0);
         iss_rd    = 5'($urandom_range(7));
         chk_rs1   = 5'($urandom_range(7));
         chk_rs2   = 5'($urandom_range(7));
         flush     = ($urandom_range(15) == 0);
         commit();
      end
      next_cycle();
      commit();
      for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clock);
      chk("sb_drain", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
